// File: rtl/apb_cvp_if_nch.sv
// APB slave bridging single-word accesses onto NUM_CH asynchronous CVP power-register
// channels; one transaction in flight, ack/error resynchronised into HCLK.
module apb_cvp_if_nch #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_CH         = 2,
  parameter int CH_LSB         = 11,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT        = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [NUM_CH-1:0]         cvp_pwr_req,
  output logic [NUM_CH-1:0]         cvp_pwr_wr_rd,
  output logic [NUM_CH*29-1:0]      cvp_pwr_add,
  output logic [NUM_CH*8-1:0]       cvp_pwr_be,
  output logic [NUM_CH*64-1:0]      cvp_pwr_data,
  input  logic [NUM_CH-1:0]         cvp_pwr_ack,
  input  logic [NUM_CH-1:0]         cvp_pwr_error,
  input  logic [NUM_CH*64-1:0]      cvp_pwr_r_data,
  output logic [2:0]                dbg_state
);

  localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ROWW     = CH_LSB - 3;
  localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  // Encoding visible on dbg_state: IDLE=0 HOLD=1 REQ=2 RESP=3 RELEASE=4.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_REQ     = 3'd2,
    S_RESP    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nx;
  logic [2*NUM_CH-1:0]     r_sync [SYNC_STAGES];
  logic [NUM_CH-1:0]       w_ack_s;
  logic [NUM_CH-1:0]       w_err_s;
  logic [CHW-1:0]          r_ch;
  logic                    r_write;
  logic                    r_upper;
  logic [ROWW-1:0]         r_row;
  logic [31:0]             r_wdata;
  logic [TW-1:0]           r_tmo;
  logic                    r_pready;
  logic                    r_pslverr;
  logic [31:0]             r_prdata;
  logic [APB_ADDR_WIDTH+CHW-1:0] w_addr_ext;
  logic                    w_unused_addr;
  logic [CHW-1:0]          w_ch_in;
  logic                    w_ch_ok;
  logic                    w_start;
  logic                    w_tmo;
  logic                    w_ack_sel;
  logic                    w_err_sel;
  logic [63:0]             w_rdata_sel;
  logic                    w_resp_err;
  logic [31:0]             w_resp_data;

  // Channel bits above the APB address read as zero.
  assign w_addr_ext    = {{CHW{1'b0}}, PADDR};
  assign w_unused_addr = ^w_addr_ext;
  assign w_ch_in       = w_addr_ext[CH_LSB +: CHW];
  assign w_ch_ok       = (int'(w_ch_in) < NUM_CH);
  assign w_start       = PSEL & PENABLE & ~r_pready;
  assign w_tmo         = (TIMEOUT != 0) && (r_tmo == TW'(TMO_LAST));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= {cvp_pwr_error, cvp_pwr_ack};
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_ack_s = r_sync[SYNC_STAGES-1][NUM_CH-1:0];
  assign w_err_s = r_sync[SYNC_STAGES-1][2*NUM_CH-1:NUM_CH];

  always_comb begin
    w_ack_sel   = 1'b0;
    w_err_sel   = 1'b0;
    w_rdata_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch == CHW'(i)) begin
        w_ack_sel   = w_ack_s[i];
        w_err_sel   = w_err_s[i];
        w_rdata_sel = cvp_pwr_r_data[i*64 +: 64];
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ch    <= '0;
      r_write <= 1'b0;
      r_upper <= 1'b0;
      r_row   <= '0;
      r_wdata <= '0;
    end else if (r_state == S_IDLE && w_start) begin
      r_ch    <= w_ch_in;
      r_write <= PWRITE;
      r_upper <= PADDR[2];
      r_row   <= PADDR[CH_LSB-1:3];
      r_wdata <= PWDATA;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                r_tmo <= '0;
    else if (r_state == S_REQ) r_tmo <= r_tmo + TW'(1);
    else                       r_tmo <= '0;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // HOLD and RELEASE both wait for the channel's ack to be low, so a stale
  // ack from an aborted request can never complete a later one.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_state_nx = w_ch_ok ? S_HOLD : S_RESP;
      S_HOLD:    if (!w_ack_sel) w_state_nx = S_REQ;
      S_REQ:     if (w_ack_sel || w_tmo) w_state_nx = S_RESP;
      S_RESP:    w_state_nx = S_RELEASE;
      S_RELEASE: if (!w_ack_sel) w_state_nx = S_IDLE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cvp_pwr_req   = '0;
    cvp_pwr_wr_rd = '0;
    cvp_pwr_add   = '0;
    cvp_pwr_be    = '0;
    cvp_pwr_data  = '0;
    if (r_state == S_REQ) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_ch == CHW'(i)) begin
          cvp_pwr_req[i]           = 1'b1;
          cvp_pwr_wr_rd[i]         = ~r_write;
          cvp_pwr_add[i*29 +: 29]  = 29'(r_row);
          cvp_pwr_be[i*8 +: 8]     = r_upper ? 8'hF0 : 8'h0F;
          cvp_pwr_data[i*64 +: 64] = r_upper ? {r_wdata, 32'h0} : {32'h0, r_wdata};
        end
      end
    end
    // Ack wins over a coincident timeout; every other way into RESP is an error.
    if (r_state == S_REQ && w_ack_sel) begin
      w_resp_err  = w_err_sel;
      w_resp_data = r_write ? 32'h0 : (r_upper ? w_rdata_sel[63:32] : w_rdata_sel[31:0]);
    end else begin
      w_resp_err  = 1'b1;
      w_resp_data = 32'h0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_pready  <= (w_state_nx == S_RESP);
      r_pslverr <= (w_state_nx == S_RESP) & w_resp_err;
      r_prdata  <= (w_state_nx == S_RESP) ? w_resp_data : 32'h0;
    end
  end

  assign PREADY    = r_pready;
  assign PSLVERR   = r_pslverr;
  assign PRDATA    = r_prdata;
  assign dbg_state = r_state;

endmodule
